// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - Breakout game sequencer: serve delay, ball motion enable, lives, end of game.
// Optional: define BONUS_LIFE_EN to award a life every BONUS_HITS bar contacts.
module game_ctrl #(
  parameter int LIVES        = 3,
  parameter int LIFE_W       = 2,
  parameter int SERVE_CYCLES = 50000000,
  parameter int BONUS_HITS   = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              btn_start,
  input  logic              hit_bar,
  input  logic              ball_lost,
  input  logic              bricks_clear,
  output logic              start,
  output logic              hit_pulse,
  output logic              ball_run,
  output logic              ball_reset,
  output logic [LIFE_W-1:0] lives,
  output logic              game_over,
  output logic              win,
  output logic [2:0]        state
);

  localparam int TMR_W = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
  localparam logic [TMR_W-1:0]  TMR_LOAD   = TMR_W'(SERVE_CYCLES - 1);
  localparam logic [LIFE_W-1:0] LIVES_INIT = LIFE_W'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_MISS  = 3'd3,
    S_OVER  = 3'd4,
    S_WIN   = 3'd5
  } state_t;

  state_t            cur, nxt;
  logic [TMR_W-1:0]  tmr, tmr_nxt;
  logic [LIFE_W-1:0] lives_nxt;
  logic              btn_q, hit_q;
  logic              btn_rise, hit_rise;
  logic              new_game, hit_nxt;

`ifdef BONUS_LIFE_EN
  localparam int BCNT_W = $clog2(BONUS_HITS) + 1;
  localparam logic [LIFE_W-1:0] LIVES_MAX = '1;
  logic [BCNT_W-1:0] bcnt, bcnt_nxt;
`else
  localparam int unused_bonus_hits = BONUS_HITS;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cur <= S_IDLE;
    else       cur <= nxt;
  end

  always_comb begin
    btn_rise  = btn_start & ~btn_q;
    hit_rise  = hit_bar & ~hit_q;
    nxt       = cur;
    tmr_nxt   = tmr;
    lives_nxt = lives;
    new_game  = 1'b0;
    hit_nxt   = (cur == S_PLAY) && hit_rise;
    case (cur)
      S_IDLE, S_OVER, S_WIN: begin
        if (btn_rise) begin
          nxt       = S_SERVE;
          new_game  = 1'b1;
          lives_nxt = LIVES_INIT;
          tmr_nxt   = TMR_LOAD;
        end
      end
      S_SERVE: begin
        if (tmr == '0) nxt = S_PLAY;
        else           tmr_nxt = tmr - 1'b1;
      end
      S_PLAY: begin
        if (bricks_clear)   nxt = S_WIN;
        else if (ball_lost) nxt = S_MISS;
      end
      S_MISS: begin
        if (lives <= LIFE_W'(1)) begin
          lives_nxt = '0;
          nxt       = S_OVER;
        end else begin
          lives_nxt = lives - 1'b1;
          nxt       = S_SERVE;
          tmr_nxt   = TMR_LOAD;
        end
      end
      default: nxt = S_IDLE;
    endcase
`ifdef BONUS_LIFE_EN
    // Bonus lands on the same edge as the pulse; only PLAY issues pulses, so no MISS/new-game clash.
    bcnt_nxt = bcnt;
    if (new_game) begin
      bcnt_nxt = '0;
    end else if (hit_nxt) begin
      if (bcnt == BCNT_W'(BONUS_HITS - 1)) begin
        bcnt_nxt = '0;
        if (lives != LIVES_MAX) lives_nxt = lives + 1'b1;
      end else begin
        bcnt_nxt = bcnt + 1'b1;
      end
    end
`endif
  end

  // Outputs decode the next state so they line up with the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmr        <= '0;
      lives      <= LIVES_INIT;
      btn_q      <= 1'b1;
      hit_q      <= 1'b1;
      start      <= 1'b0;
      hit_pulse  <= 1'b0;
      ball_run   <= 1'b0;
      ball_reset <= 1'b1;
      game_over  <= 1'b0;
      win        <= 1'b0;
    end else begin
      tmr        <= tmr_nxt;
      lives      <= lives_nxt;
      btn_q      <= btn_start;
      hit_q      <= hit_bar;
      start      <= new_game;
      hit_pulse  <= hit_nxt;
      ball_run   <= (nxt == S_PLAY);
      ball_reset <= (nxt != S_PLAY);
      game_over  <= (nxt == S_OVER);
      win        <= (nxt == S_WIN);
    end
  end

`ifdef BONUS_LIFE_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) bcnt <= '0;
    else       bcnt <= bcnt_nxt;
  end
`endif

  assign state = cur;

endmodule
